// File: rtl/subr8u_pkg.sv
// subr8u_pkg: shared types and helpers for the bit-serial unsigned subtractor.
//   state_t       FSM states (IDLE/RUN/DONE)
//   SUBR_WIDTH    default addend width
//   SUBR_CNT_W    bit-counter width for the default width
//   mod3_add()    residue addition modulo 3
package subr8u_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SUBR_WIDTH = 8;
    localparam int SUBR_CNT_W = $clog2(SUBR_WIDTH + 2);

    // Both operands are residues in 0..2, so one conditional subtract suffices.
    function automatic logic [1:0] mod3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

endpackage

// File: rtl/subr8u_res3.sv
// subr8u_res3: serial mod-3 residue accumulator, LSB first.
// Bit weights alternate 1,2,1,2,... since 2^k mod 3 alternates that way.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   i_clr      clear residue and restart at weight 1
//   i_en       accumulate i_bit at the current weight, then toggle weight
//   i_bit      serial input bit
//   o_res      accumulated residue (registered)
//   o_res_nxt  residue including the current i_bit (for same-edge decisions)
module subr8u_res3
    import subr8u_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clr,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [1:0] o_res,
    output logic [1:0] o_res_nxt
);

    logic [1:0] r_res;
    logic       r_wt;   // 0: weight 1, 1: weight 2
    logic [1:0] w_add;

    assign w_add     = i_bit ? (r_wt ? 2'd2 : 2'd1) : 2'd0;
    assign o_res_nxt = mod3_add(r_res, w_add);
    assign o_res     = r_res;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_res <= 2'd0;
            r_wt  <= 1'b0;
        end else if (i_en) begin
            r_res <= o_res_nxt;
            r_wt  <= ~r_wt;
        end
    end

endmodule

// File: rtl/subr8u_serial.sv
// subr8u_serial: bit-serial unsigned subtractor recovering B = S - A, LSB first.
// Optional feature macro: SUBR8U_RESIDUE_CHECK_EN (mod-3 residue self-check).
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (ready only in IDLE)
//   s_in [WIDTH:0]        minuend (sum)
//   a_in [WIDTH-1:0]      subtrahend (known addend)
//   out_valid / out_ready result handshake (held until accepted)
//   b_out [WIDTH-1:0]     low bits of S - A
//   underflow             S < A
//   overflow              S - A > 2^WIDTH - 1 without underflow
//   res_err               residue mismatch (0 when feature disabled)
module subr8u_serial
    import subr8u_pkg::*;
#(
    parameter int WIDTH = SUBR_WIDTH
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   s_in,
    input  logic [WIDTH-1:0] a_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] b_out,
    output logic             underflow,
    output logic             overflow,
    output logic             res_err
);

    // Counts 0..WIDTH over the WIDTH+1 bit positions.
    localparam int CW = $clog2(WIDTH + 2);

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [WIDTH:0]  r_s, r_a, r_res;
    logic            r_brw;
    logic            r_in_ready, r_out_valid;

    logic w_d, w_brw_nxt, w_last, w_acc;

    assign w_d       = r_s[0] ^ r_a[0] ^ r_brw;
    assign w_brw_nxt = (~r_s[0] & r_a[0]) | (~(r_s[0] ^ r_a[0]) & r_brw);
    assign w_last    = (r_cnt == CW'(WIDTH));
    assign w_acc     = r_in_ready & in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_s         <= '0;
            r_a         <= '0;
            r_res       <= '0;
            r_brw       <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // First cycle out of reset raises ready; accept needs it high.
                    r_in_ready <= 1'b1;
                    if (w_acc) begin
                        r_s        <= s_in;
                        r_a        <= {1'b0, a_in};
                        r_brw      <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Difference bits enter at the MSB so bit 0 lands at r_res[0].
                    r_res <= {w_d, r_res[WIDTH:1]};
                    r_s   <= r_s >> 1;
                    r_a   <= r_a >> 1;
                    r_brw <= w_brw_nxt;
                    if (w_last) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign b_out     = r_out_valid ? r_res[WIDTH-1:0] : '0;
    assign underflow = r_out_valid & r_brw;
    assign overflow  = r_out_valid & r_res[WIDTH] & ~r_brw;

`ifdef SUBR8U_RESIDUE_CHECK_EN
    // D residue is taken from the result register itself (one cycle behind the
    // datapath) so a corrupted stored bit is caught; the final bit comes from w_d.
    localparam logic [1:0] LAST_W = (WIDTH % 2 == 0) ? 2'd1 : 2'd2;

    logic       w_run;
    logic [1:0] w_rs, w_ra, w_rd, w_rs_n, w_ra_n, w_rd_n, w_d_last;
    logic       r_res_err;

    assign w_run    = (r_state == ST_RUN);
    assign w_d_last = w_d ? LAST_W : 2'd0;

    subr8u_res3 u_res_s (.clk(clk), .rst(rst), .i_clr(w_acc), .i_en(w_run),
                         .i_bit(r_s[0]), .o_res(w_rs), .o_res_nxt(w_rs_n));
    subr8u_res3 u_res_a (.clk(clk), .rst(rst), .i_clr(w_acc), .i_en(w_run),
                         .i_bit(r_a[0]), .o_res(w_ra), .o_res_nxt(w_ra_n));
    subr8u_res3 u_res_d (.clk(clk), .rst(rst), .i_clr(w_acc),
                         .i_en(w_run && (r_cnt != '0)),
                         .i_bit(r_res[WIDTH]), .o_res(w_rd), .o_res_nxt(w_rd_n));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_res_err <= 1'b0;
        end else if (w_run && w_last) begin
            r_res_err <= ~w_brw_nxt &
                         (mod3_add(mod3_add(w_ra_n, w_rd_n), w_d_last) != w_rs_n);
        end else if (r_state == ST_DONE && out_ready) begin
            r_res_err <= 1'b0;
        end
    end

    assign res_err = r_res_err & r_out_valid;
`else
    assign res_err = 1'b0;
`endif

endmodule

// File: tb/tb_subr8u_serial.sv
module tb_subr8u_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [8:0] s_in;
    logic [7:0] a_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] b_out;
    logic       underflow;
    logic       overflow;
    logic       res_err;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    subr8u_serial #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .s_in(s_in), .a_in(a_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .b_out(b_out), .underflow(underflow), .overflow(overflow),
        .res_err(res_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand pair, wait for the result, optionally stall the consumer
    // for 'hold' cycles while poking in_valid, then complete the handshake.
    task automatic do_op(input logic [8:0] s, input logic [7:0] a, input int hold);
        int       lat;
        int       diff;
        logic [7:0] exp_b;
        logic     exp_uf, exp_of;
        diff   = int'(s) - int'(a);
        exp_b  = 8'(diff & 255);
        exp_uf = (diff < 0);
        exp_of = (diff > 255);

        chk("ready_idle", 32'(in_ready), 32'd1);
        s_in = s; a_in = a; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        s_in = 9'(($urandom));
        a_in = 8'(($urandom));
        lat = 0;
        while (!out_valid && lat < 30) begin
            chk("ready_busy", 32'(in_ready), 32'd0);
            tick();
            lat++;
        end
        chk("latency", 32'(lat), 32'd9);
        chk("b_out", 32'(b_out), 32'(exp_b));
        chk("underflow", 32'(underflow), 32'(exp_uf));
        chk("overflow", 32'(overflow), 32'(exp_of));
        chk("res_err", 32'(res_err), 32'd0);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            s_in = 9'($urandom);
            a_in = 8'($urandom);
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_b", 32'(b_out), 32'(exp_b));
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; s_in = '0; a_in = '0;
        repeat (3) tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_flags", {29'd0, underflow, overflow, res_err}, 32'd0);
        chk("rst_b", 32'(b_out), 32'd0);
        rst = 1'b0;
        tick();

        // Directed cases
        do_op(9'h0FF, 8'h0F, 0);
        do_op(9'h1FE, 8'hFF, 0);
        do_op(9'h005, 8'h07, 0);
        do_op(9'h1FF, 8'h00, 0);
        do_op(9'h100, 8'h00, 0);
        do_op(9'h000, 8'h00, 0);
        do_op(9'h000, 8'hFF, 0);
        // Stalled consumer; the poked operands must be ignored
        do_op(9'h0AA, 8'h33, 5);
        // Back-to-back: accept one cycle after the handshake
        do_op(9'h123, 8'h45, 0);

        // Reset mid-RUN (4th RUN cycle)
        s_in = 9'h0F0; a_in = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_valid", 32'(out_valid), 32'd0);
        chk("abort_b", 32'(b_out), 32'd0);
        chk("abort_flags", {29'd0, underflow, overflow, res_err}, 32'd0);
        chk("abort_ready", 32'(in_ready), 32'd0);
        tick();
        do_op(9'h100, 8'h01, 0);

        // Reset while holding a result in DONE
        s_in = 9'h1FF; a_in = 8'h01; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        chk("done_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("done_abort_valid", 32'(out_valid), 32'd0);
        chk("done_abort_b", 32'(b_out), 32'd0);
        tick();

        // Randomized operands
        for (int k = 0; k < 40; k++) begin
            do_op(9'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/subr8u_serial.md
# subr8u_serial

Bit-serial 8-bit unsigned subtractor: the inverse-direction counterpart to the team's 8-bit unsigned adders. Given a 9-bit sum S and an 8-bit addend A, it recovers the other addend B = S − A, one bit per clock, LSB first. Range flags report when no valid 8-bit B exists. It sits behind the adder library as a low-area, handshaked recovery/check unit, with an optional residue self-check for fault resilience.

## Interface
- WIDTH, 8, addend width; S is WIDTH+1 bits; the datapath processes WIDTH+1 bit positions.
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands (high only in IDLE, low while rst high).
- s_in  in  WIDTH+1  minuend (sum).
- a_in  in  WIDTH  subtrahend (known addend).
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- b_out  out  WIDTH  low WIDTH bits of S − A.
- underflow  out  1  S < A (final borrow set).
- overflow  out  1  S − A > 2^WIDTH − 1 and no underflow.
- res_err  out  1  residue check mismatch (tied 0 unless SUBR8U_RESIDUE_CHECK_EN).

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE, borrow=0, bit counter=0, shift regs=0. While rst is high, out_valid, b_out, underflow, overflow, res_err and in_ready are all 0.
- IDLE: in_ready=1. On in_valid&&in_ready, capture s_in into a (WIDTH+1)-bit shift reg and a_in zero-extended to WIDTH+1 bits; clear borrow and counter; go to RUN.
- RUN: each cycle, d = s0 ^ a0 ^ borrow and borrow' = (~s0 & a0) | (~(s0 ^ a0) & borrow). Shift d into the result reg from the MSB side and shift both operand regs right. Counter increments; after the WIDTH+1th bit go to DONE.
- DONE: out_valid=1. b_out = result[WIDTH-1:0], underflow = borrow, overflow = result[WIDTH] & ~borrow. On out_ready go to IDLE. Outputs are stable while waiting.
- Underflow case: b_out still holds the two's-complement low bits, e.g. 5 − 7 gives 0xFE.
- in_ready is 0 in RUN and DONE. There is no operand overlap, and in_valid is ignored outside IDLE.
- rst asserted mid-RUN or in DONE aborts with no output and returns to IDLE next edge.

## Timing
- Operand accept at edge k; RUN occupies edges k+1 … k+WIDTH+1; out_valid is high from edge k+WIDTH+1. Latency is WIDTH+1 = 9 cycles.
- Output handshake at edge m → IDLE; the next accept is earliest at edge m+1. Minimum initiation interval is WIDTH+3 = 11 cycles.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Configuration
- SUBR8U_RESIDUE_CHECK_EN defined:
  - During RUN, accumulate mod-3 residues of S, A and the difference serially, using bit weights 1,2,1,2,….
  - In DONE with underflow=0, res_err = (res(A)+res(D)) mod 3 ≠ res(S), where D is the full (WIDTH+1)-bit difference.
  - res_err is forced 0 when underflow=1.
  - res_err is registered and valid with out_valid.
- Not defined: no residue logic is instantiated, and res_err is constant 0.

## Structure
- Package subr8u_pkg: state enum (IDLE/RUN/DONE), default WIDTH, counter width constant $clog2(WIDTH+2), and a mod-3 add function.
- One sub-module, subr8u_res3: a serial mod-3 residue accumulator (bit in, weight toggle, clear, 2-bit residue out). Three instances are created only under SUBR8U_RESIDUE_CHECK_EN.

## Test plan
- s_in=0x0FF, a_in=0x0F, out_ready=1 → out_valid 9 cycles after accept; b_out=0xF0, underflow=0, overflow=0.
- s_in=0x1FE, a_in=0xFF → b_out=0xFF, no flags.
- s_in=0x005, a_in=0x07 → underflow=1, overflow=0, b_out=0xFE; s_in=0x1FF, a_in=0x00 → overflow=1, b_out=0xFF.
- out_ready held low 5 cycles in DONE → out_valid and b_out stable, in_ready=0, a new in_valid is ignored. Release → next operand accepted one cycle after the handshake.
- rst pulsed on the 4th RUN cycle → all outputs 0 next cycle, state IDLE. A new operand s_in=0x100, a_in=0x01 then yields b_out=0xFF.
- With the macro: force one result-reg bit flipped mid-RUN on s_in=0x0AA, a_in=0x33 → res_err=1. Unforced run → b_out=0x77, res_err=0.
